// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 opcode constants, NOP encoding and fetch FSM state type
package riscv_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, HALT} fetch_state_t;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory request/response bus
//   imem_req    one-cycle request pulse (master -> slave)
//   imem_addr   fetch address (master -> slave)
//   imem_rvalid read data valid (slave -> master)
//   imem_rdata  instruction word (slave -> master)
interface instr_fetch_if #(parameter int XLEN = 32);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/instr_fetch_pc_next.sv
// pc_next: PC+4 and next-PC select between sequential and word-aligned redirect target
//   pc_i        current PC
//   br_target_i redirect target
//   sel_i       1 = redirect, 0 = sequential
//   pc_inc_o    PC+4 (wraps modulo 2^XLEN)
//   pc_next_o   selected next PC, low two bits cleared on redirect
//   misalign_o  redirect target not word aligned (IF_MISALIGN_TRAP_EN only)
module pc_next #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            sel_i,
    output logic [XLEN-1:0] pc_inc_o,
    output logic [XLEN-1:0] pc_next_o
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic            misalign_o
`endif
);
    assign pc_inc_o  = pc_i + XLEN'(4);
    assign pc_next_o = sel_i ? (br_target_i & ~XLEN'(3)) : pc_inc_o;
`ifdef IF_MISALIGN_TRAP_EN
    assign misalign_o = sel_i && (br_target_i[1:0] != 2'b00);
`endif
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding fetch stage with PC, instruction register and decode field split
//   clk, rst          clock, async active-high reset
//   imem              instr_fetch_if.master instruction memory bus
//   instr_valid       held instruction valid; instr_ready retires it
//   OpCode..Funct7    fields of the held instruction
//   PC, PCInc         address of held instruction and its PC+4
//   NextPCSrc,BrTarget redirect select/target, sampled on the retire cycle
//   misaligned        sticky misaligned-redirect flag (only with IF_MISALIGN_TRAP_EN)
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_if.master       imem,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [6:0]          OpCode,
    output logic [4:0]          Rd,
    output logic [2:0]          Funct3,
    output logic [4:0]          Rs1,
    output logic [4:0]          Rs2,
    output logic [6:0]          Funct7,
    output logic [XLEN-1:0]     PC,
    output logic [XLEN-1:0]     PCInc,
    input  logic                NextPCSrc,
    input  logic [XLEN-1:0]     BrTarget
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic                misaligned
`endif
);
    fetch_state_t    state_q;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q;
    logic            req_q, valid_q;
`ifdef IF_MISALIGN_TRAP_EN
    logic            mis_q, mis_d;
`endif
    pc_next #(.XLEN(XLEN)) u_pc_next (
        .pc_i        (pc_q),
        .br_target_i (BrTarget),
        .sel_i       (NextPCSrc),
        .pc_inc_o    (PCInc),
        .pc_next_o   (pc_d)
`ifdef IF_MISALIGN_TRAP_EN
        ,
        .misalign_o  (mis_d)
`endif
    );
    // rvalid is only looked at in WAIT, so stale responses after a reset are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= NOP_INSTR;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH: begin
                    state_q <= WAIT;
                    req_q   <= 1'b0;
                end
                WAIT: if (imem.imem_rvalid) begin
                    ir_q    <= imem.imem_rdata;
                    valid_q <= 1'b1;
                    state_q <= HOLD;
                end
                HOLD: if (instr_ready) begin
                    valid_q <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
                    if (mis_d) begin
                        mis_q   <= 1'b1;
                        state_q <= HALT;
                    end else begin
                        pc_q    <= pc_d;
                        req_q   <= 1'b1;
                        state_q <= FETCH;
                    end
`else
                    pc_q    <= pc_d;
                    req_q   <= 1'b1;
                    state_q <= FETCH;
`endif
                end
                default: ;
            endcase
        end
    end
    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign instr_valid    = valid_q;
    assign PC             = pc_q;
    assign OpCode         = ir_q[6:0];
    assign Rd             = ir_q[11:7];
    assign Funct3         = ir_q[14:12];
    assign Rs1            = ir_q[19:15];
    assign Rs2            = ir_q[24:20];
    assign Funct7         = ir_q[31:25];
`ifdef IF_MISALIGN_TRAP_EN
    assign misaligned     = mis_q;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid, instr_ready, NextPCSrc;
    logic [6:0]  OpCode, Funct7;
    logic [4:0]  Rd, Rs1, Rs2;
    logic [2:0]  Funct3;
    logic [31:0] PC, PCInc, BrTarget;
`ifdef IF_MISALIGN_TRAP_EN
    logic        misaligned;
`endif
    int checks = 0;
    int errors = 0;
    instr_fetch_if #(.XLEN(32)) bus ();
    instr_fetch #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (bus),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .OpCode      (OpCode),
        .Rd          (Rd),
        .Funct3      (Funct3),
        .Rs1         (Rs1),
        .Rs2         (Rs2),
        .Funct7      (Funct7),
        .PC          (PC),
        .PCInc       (PCInc),
        .NextPCSrc   (NextPCSrc),
        .BrTarget    (BrTarget)
`ifdef IF_MISALIGN_TRAP_EN
        ,
        .misaligned  (misaligned)
`endif
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end
    initial begin
        rst = 1'b1; instr_ready = 1'b0; NextPCSrc = 1'b0; BrTarget = '0;
        bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        repeat (2) step();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_opcode", 32'(OpCode), 32'h13);
        chk("rst_rd", 32'(Rd), 32'h0);
        rst = 1'b0;
        step();
        chk("c1_req", 32'(bus.imem_req), 32'd1);
        chk("c1_addr", bus.imem_addr, 32'h0);
        chk("c1_valid", 32'(instr_valid), 32'd0);
        step();
        chk("c2_req", 32'(bus.imem_req), 32'd0);
        chk("c2_valid", 32'(instr_valid), 32'd0);
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_0033;
        step();
        bus.imem_rvalid = 1'b0;
        chk("c3_valid", 32'(instr_valid), 32'd1);
        chk("c3_opcode", 32'(OpCode), 32'h33);
        chk("c3_pc", PC, 32'h0);
        chk("c3_pcinc", PCInc, 32'h4);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("seq_req", 32'(bus.imem_req), 32'd1);
        chk("seq_addr", bus.imem_addr, 32'h4);
        chk("seq_valid", 32'(instr_valid), 32'd0);
        step();
        chk("lat_req0", 32'(bus.imem_req), 32'd0);
        instr_ready = 1'b1;
        repeat (3) begin
            step();
            chk("lat_valid", 32'(instr_valid), 32'd0);
            chk("lat_req", 32'(bus.imem_req), 32'd0);
            chk("lat_pc", PC, 32'h4);
        end
        instr_ready = 1'b0;
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h40B5_0533;
        step();
        chk("sub_valid", 32'(instr_valid), 32'd1);
        chk("sub_opcode", 32'(OpCode), 32'h33);
        chk("sub_rd", 32'(Rd), 32'h0A);
        chk("sub_f3", 32'(Funct3), 32'h0);
        chk("sub_rs1", 32'(Rs1), 32'h0A);
        chk("sub_rs2", 32'(Rs2), 32'h0B);
        chk("sub_f7", 32'(Funct7), 32'h20);
        chk("sub_pc", PC, 32'h4);
        chk("sub_pcinc", PCInc, 32'h8);
        bus.imem_rdata = 32'hFFFF_FFFF;
        repeat (5) begin
            step();
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_req", 32'(bus.imem_req), 32'd0);
            chk("hold_pc", PC, 32'h4);
            chk("hold_rs2", 32'(Rs2), 32'h0B);
            chk("hold_f7", 32'(Funct7), 32'h20);
        end
        bus.imem_rvalid = 1'b0;
        instr_ready = 1'b1; NextPCSrc = 1'b1; BrTarget = 32'h100;
        step();
        instr_ready = 1'b0; NextPCSrc = 1'b0;
        chk("br_req", 32'(bus.imem_req), 32'd1);
        chk("br_addr", bus.imem_addr, 32'h100);
        step();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_006F;
        step();
        bus.imem_rvalid = 1'b0;
        chk("br_pc", PC, 32'h100);
        chk("br_pcinc", PCInc, 32'h104);
        chk("br_opcode", 32'(OpCode), 32'h6F);
        instr_ready = 1'b1; NextPCSrc = 1'b1; BrTarget = 32'hFFFF_FFFC;
        step();
        instr_ready = 1'b0; NextPCSrc = 1'b0;
        chk("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        step();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_0013;
        step();
        bus.imem_rvalid = 1'b0;
        chk("top_pc", PC, 32'hFFFF_FFFC);
        chk("wrap_pcinc", PCInc, 32'h0);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("wrap_addr", bus.imem_addr, 32'h0);
        chk("wrap_req", 32'(bus.imem_req), 32'd1);
        step();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_0033;
        step();
        bus.imem_rvalid = 1'b0;
        chk("pre_mis_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1; NextPCSrc = 1'b1; BrTarget = 32'h102;
        step();
        instr_ready = 1'b0; NextPCSrc = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
        chk("mis_flag", 32'(misaligned), 32'd1);
        repeat (3) begin
            step();
            chk("halt_req", 32'(bus.imem_req), 32'd0);
            chk("halt_valid", 32'(instr_valid), 32'd0);
        end
`else
        chk("mis_req", 32'(bus.imem_req), 32'd1);
        chk("mis_addr", bus.imem_addr, 32'h100);
        step();
`endif
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_req", 32'(bus.imem_req), 32'd0);
        chk("arst_pc", PC, 32'h0);
        chk("arst_opcode", 32'(OpCode), 32'h13);
`ifdef IF_MISALIGN_TRAP_EN
        chk("arst_mis", 32'(misaligned), 32'd0);
`endif
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        rst = 1'b0;
        step();
        chk("rs_req", 32'(bus.imem_req), 32'd1);
        chk("rs_addr", bus.imem_addr, 32'h0);
        chk("rs_valid", 32'(instr_valid), 32'd0);
        step();
        chk("stale_valid", 32'(instr_valid), 32'd0);
        chk("stale_opcode", 32'(OpCode), 32'h13);
        bus.imem_rvalid = 1'b0;
        step();
        chk("rs_wait", 32'(instr_valid), 32'd0);
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_0033;
        step();
        bus.imem_rvalid = 1'b0;
        chk("rs_valid2", 32'(instr_valid), 32'd1);
        chk("rs_opcode", 32'(OpCode), 32'h33);
        chk("rs_pc", PC, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
